// File: rtl/microcode_sequencer.sv
// Microword sequencer: fetches {opcode,operand} words, drives instr/imm and the shared bus.
// Optional watchdog on runaway programs is enabled by defining SEQ_WDOG_EN.
module microcode_sequencer #(
  parameter logic [3:0] START_PC   = 4'h0,
  parameter logic [6:0] WDOG_LIMIT = 7'd64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [3:0] pc_addr,
  input  logic [7:0] rom_data,
  output logic [3:0] instr,
  output logic [3:0] imm,
  inout  wire  [3:0] bus,
  output logic [3:0] data_out,
  output logic       data_valid,
  output logic       wdog_err
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC} state_t;

  state_t     r_state;
  logic [3:0] r_pc;
  logic [7:0] r_uword;
  logic [3:0] r_instr;
  logic [3:0] r_imm;
  logic       r_bus_oe;
  logic [3:0] r_bus_dat;
  logic [3:0] r_data_out;
  logic       r_data_valid;
  logic       r_busy;
  logic       r_done;

  wire [3:0] w_op       = r_uword[7:4];
  wire [3:0] w_opnd     = r_uword[3:0];
  wire [3:0] w_fetch_op = rom_data[7:4];
  wire [3:0] w_pc_inc   = r_pc + 4'd1;
  wire       w_is_read  = (w_op >= 4'h6) && (w_op <= 4'hC);
  wire       w_jz_take  = (r_data_out == 4'h0);
  wire       w_trip;

`ifdef SEQ_WDOG_EN
  logic [6:0] r_wdog_cnt;
  logic       r_wdog_err;

  // Trip on the EXEC that would bring the count to the limit, unless it is the HALT itself.
  assign w_trip = (r_state == S_EXEC) && (w_op != 4'hF) &&
                  ((r_wdog_cnt + 7'd1) >= WDOG_LIMIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wdog_cnt <= 7'd0;
      r_wdog_err <= 1'b0;
    end else if ((r_state == S_IDLE) && start) begin
      r_wdog_cnt <= 7'd0;
      r_wdog_err <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_wdog_cnt <= r_wdog_cnt + 7'd1;
      if (w_trip) r_wdog_err <= 1'b1;
    end
  end

  assign wdog_err = r_wdog_err;
`else
  assign w_trip   = 1'b0;
  assign wdog_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_pc         <= START_PC;
      r_uword      <= 8'h00;
      r_instr      <= 4'h0;
      r_imm        <= 4'h0;
      r_bus_oe     <= 1'b0;
      r_bus_dat    <= 4'h0;
      r_data_out   <= 4'h0;
      r_data_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done       <= 1'b0;
      r_data_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_instr  <= 4'h0;
          r_bus_oe <= 1'b0;
          if (start) begin
            r_pc    <= START_PC;
            r_state <= S_FETCH;
            r_busy  <= 1'b1;
          end
        end
        S_FETCH: begin
          // Outputs for EXEC are loaded here so they are stable for the whole EXEC cycle.
          r_uword   <= rom_data;
          r_state   <= S_EXEC;
          r_bus_oe  <= (w_fetch_op == 4'h4) || (w_fetch_op == 4'h5);
          r_bus_dat <= rom_data[3:0];
          if (w_fetch_op <= 4'hC) begin
            r_instr <= w_fetch_op;
            r_imm   <= rom_data[3:0];
          end else begin
            r_instr <= 4'h0;
          end
        end
        S_EXEC: begin
          r_instr  <= 4'h0;
          r_bus_oe <= 1'b0;
          if (w_is_read) begin
            r_data_out   <= bus;
            r_data_valid <= 1'b1;
          end
          if (w_trip || (w_op == 4'hF)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_FETCH;
            case (w_op)
              4'hE:    r_pc <= w_opnd;
              4'hD:    r_pc <= w_jz_take ? w_opnd : w_pc_inc;
              default: r_pc <= w_pc_inc;
            endcase
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus        = r_bus_oe ? r_bus_dat : 4'bzzzz;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pc_addr    = r_pc;
  assign instr      = r_instr;
  assign imm        = r_imm;
  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Scoreboard bench for microcode_sequencer: stimulus queues expected EXEC/read/done
// events, a negedge monitor pops and compares them as the DUT presents them.
module tb_microcode_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, data_valid, wdog_err;
  logic [3:0] pc_addr, instr, imm, data_out;
  logic [7:0] rom_data;
  wire  [3:0] bus;
  logic       tb_drv = 1'b0;
  logic [3:0] tb_val = 4'h0;
  logic [7:0] rom [16];

  logic       start2 = 1'b0;
  logic       busy2, done2, data_valid2, wdog_err2;
  logic [3:0] pc_addr2, instr2, imm2, data_out2;
  logic [7:0] rom2_data;
  wire  [3:0] bus2;
  logic [7:0] rom2 [16];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int done_cnt = 0;

  typedef struct {
    logic [3:0] pc;
    logic [3:0] ins;
    logic [3:0] im;
    logic [3:0] busv;
    bit         chk_bus;
  } exec_t;
  typedef struct {
    int lat;
    bit werr;
  } done_t;

  exec_t      exec_q[$];
  logic [3:0] dv_q[$];
  done_t      done_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus       = tb_drv ? tb_val : 4'bzzzz;
  assign rom_data  = rom[pc_addr];
  assign rom2_data = rom2[pc_addr2];

  microcode_sequencer #(.START_PC(4'h0), .WDOG_LIMIT(7'd8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .pc_addr(pc_addr), .rom_data(rom_data), .instr(instr), .imm(imm), .bus(bus),
    .data_out(data_out), .data_valid(data_valid), .wdog_err(wdog_err)
  );

  microcode_sequencer #(.START_PC(4'hF)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
    .pc_addr(pc_addr2), .rom_data(rom2_data), .instr(instr2), .imm(imm2), .bus(bus2),
    .data_out(data_out2), .data_valid(data_valid2), .wdog_err(wdog_err2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic exp_exec(input logic [3:0] pc, input logic [3:0] ins, input logic [3:0] im,
                          input logic [3:0] bv, input bit cb);
    exec_t e;
    e.pc = pc; e.ins = ins; e.im = im; e.busv = bv; e.chk_bus = cb;
    exec_q.push_back(e);
  endtask

  task automatic exp_done(input int lat, input bit werr);
    done_t d;
    d.lat = lat; d.werr = werr;
    done_q.push_back(d);
  endtask

  task automatic load_rom(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                          input logic [7:0] w3, input logic [7:0] w4, input logic [7:0] w5);
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    rom[0] = w0; rom[1] = w1; rom[2] = w2; rom[3] = w3; rom[4] = w4; rom[5] = w5;
  endtask

  // Returns at the negedge one cycle after start was sampled (FETCH of the first word).
  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int  base;
    bit  seen;
    base = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(negedge clk);
      if (done_cnt != base) seen = 1'b1;
    end
    chk("done_within_budget", {31'd0, seen}, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  // Monitor
  exec_t m_e;
  done_t m_d;
  logic [3:0] m_v;
  always @(negedge clk) begin
    if (instr != 4'h0) begin
      if (exec_q.size() == 0) begin
        chk("exec_unexpected_instr", {28'd0, instr}, 32'd0);
      end else begin
        m_e = exec_q.pop_front();
        $display("EXEC pc=%0h instr=%0h imm=%0h bus=%0h", pc_addr, instr, imm, bus);
        chk("exec_pc", {28'd0, pc_addr}, {28'd0, m_e.pc});
        chk("exec_instr", {28'd0, instr}, {28'd0, m_e.ins});
        chk("exec_imm", {28'd0, imm}, {28'd0, m_e.im});
        chk("exec_busy", {31'd0, busy}, 32'd1);
        if (m_e.chk_bus) chk("exec_bus_drive", {28'd0, bus}, {28'd0, m_e.busv});
      end
    end
    if (data_valid) begin
      if (dv_q.size() == 0) begin
        chk("read_unexpected", {31'd0, data_valid}, 32'd0);
      end else begin
        m_v = dv_q.pop_front();
        $display("READ data_out=%0h", data_out);
        chk("read_data_out", {28'd0, data_out}, {28'd0, m_v});
      end
    end
    if (done) begin
      done_cnt++;
      if (done_q.size() == 0) begin
        chk("done_unexpected", {31'd0, done}, 32'd0);
      end else begin
        m_d = done_q.pop_front();
        $display("DONE latency=%0d wdog_err=%0b", cyc - t0, wdog_err);
        chk("done_latency", cyc - t0, m_d.lat);
        chk("done_wdog_err", {31'd0, wdog_err}, {31'd0, m_d.werr});
        chk("done_busy_low", {31'd0, busy}, 32'd0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout actual=hang required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) rom2[i] = 8'h00;
    rom2[15] = 8'h1B;
    rom2[0]  = 8'hF0;
    load_rom(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_instr", {28'd0, instr}, 32'd0);
    chk("rst_imm", {28'd0, imm}, 32'd0);
    chk("rst_data_out", {28'd0, data_out}, 32'd0);
    chk("rst_data_valid", {31'd0, data_valid}, 32'd0);
    chk("rst_wdog_err", {31'd0, wdog_err}, 32'd0);
    chk("rst_pc", {28'd0, pc_addr}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic program: ALU op, bus write, halt
    load_rom(8'h1A, 8'h4C, 8'hF0, 8'h00, 8'h00, 8'h00);
    exp_exec(4'h0, 4'h1, 4'hA, 4'h0, 1'b0);
    exp_exec(4'h1, 4'h4, 4'hC, 4'hC, 1'b1);
    exp_done(7, 1'b0);
    start_pulse();
    chk("busy_first_cycle", {31'd0, busy}, 32'd1);
    wait_done(20);

    // Bus read
    load_rom(8'h60, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00);
    tb_drv = 1'b1; tb_val = 4'h8;
    exp_exec(4'h0, 4'h6, 4'h0, 4'h0, 1'b0);
    dv_q.push_back(4'h8);
    exp_done(5, 1'b0);
    start_pulse();
    wait_done(20);

    // JZ taken (bus=0)
    load_rom(8'h60, 8'hD5, 8'h12, 8'hF0, 8'h00, 8'hF0);
    tb_val = 4'h0;
    exp_exec(4'h0, 4'h6, 4'h0, 4'h0, 1'b0);
    dv_q.push_back(4'h0);
    exp_done(7, 1'b0);
    start_pulse();
    wait_done(20);

    // JZ not taken (bus=3): falls through to PC 2
    tb_val = 4'h3;
    exp_exec(4'h0, 4'h6, 4'h0, 4'h0, 1'b0);
    dv_q.push_back(4'h3);
    exp_exec(4'h2, 4'h1, 4'h2, 4'h0, 1'b0);
    exp_done(9, 1'b0);
    start_pulse();
    wait_done(20);
    tb_drv = 1'b0;
    chk("data_out_held_after_run", {28'd0, data_out}, 32'd3);

    // JMP to PC 3
    load_rom(8'hE3, 8'h11, 8'h11, 8'h27, 8'hF0, 8'h00);
    exp_exec(4'h3, 4'h2, 4'h7, 4'h0, 1'b0);
    exp_done(7, 1'b0);
    start_pulse();
    wait_done(20);

    // start during run and together with HALT is ignored
    load_rom(8'h1A, 8'h4C, 8'hF0, 8'h00, 8'h00, 8'h00);
    exp_exec(4'h0, 4'h1, 4'hA, 4'h0, 1'b0);
    exp_exec(4'h1, 4'h4, 4'hC, 4'hC, 1'b1);
    exp_done(7, 1'b0);
    start_pulse();
    @(negedge clk);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    chk("start_ignored_busy", {31'd0, busy}, 32'd0);
    chk("start_ignored_instr", {28'd0, instr}, 32'd0);

    // Reset during EXEC of 0x4C
    exp_exec(4'h0, 4'h1, 4'hA, 4'h0, 1'b0);
    exp_exec(4'h1, 4'h4, 4'hC, 4'hC, 1'b1);
    start_pulse();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_instr", {28'd0, instr}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_data_out", {28'd0, data_out}, 32'd0);
    chk("midrst_bus_released", {31'd0, (bus !== 4'hC)}, 32'd1);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("midrst_stays_idle", {31'd0, busy}, 32'd0);

    // PC wrap F -> 0 on the START_PC=F instance
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    @(negedge clk);
    chk("wrap_exec_instr", {28'd0, instr2}, 32'd1);
    chk("wrap_exec_imm", {28'd0, imm2}, 32'hB);
    chk("wrap_exec_pc", {28'd0, pc_addr2}, 32'hF);
    @(negedge clk);
    chk("wrap_pc_zero", {28'd0, pc_addr2}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("wrap_done", {31'd0, done2}, 32'd1);
    chk("wrap_busy_low", {31'd0, busy2}, 32'd0);
    $display("WRAP pc F->0 halted");

`ifdef SEQ_WDOG_EN
    load_rom(8'hE0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    exp_done(17, 1'b1);
    start_pulse();
    wait_done(40);
    chk("wdog_sticky", {31'd0, wdog_err}, 32'd1);
    load_rom(8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    exp_done(3, 1'b0);
    start_pulse();
    chk("wdog_cleared_on_start", {31'd0, wdog_err}, 32'd0);
    wait_done(20);
`endif

    repeat (3) @(negedge clk);
    chk("exec_queue_drained", exec_q.size(), 32'd0);
    chk("read_queue_drained", dv_q.size(), 32'd0);
    chk("done_queue_drained", done_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
